// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and defaults for the LC-3 SRAM access sequencer
// Purpose: state encoding, default bus widths / wait states, and a width helper.
// Ports: none (package).
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR,
        ST_WR_HOLD,
        ST_TURN
    } mem_state_e;

    localparam int ADDR_W_DEF  = 20;
    localparam int DATA_W_DEF  = 16;
    localparam int RD_WAIT_DEF = 2;
    localparam int WR_WAIT_DEF = 2;
    localparam int TURN_DEF    = 1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lc3_sram_ctrl_if.sv
// rtl/lc3_sram_ctrl_if.sv - request handshake and SRAM pad bundle for lc3_sram_ctrl
// Purpose: groups the control-unit request side and the async SRAM pins.
// Ports (signals): Req_rd, Req_wr, Addr, Wdata (requests in); Ready, Done, Rdata, Req_err
//   (status out); SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_*_N (pads out); SRAM_DQ_in (pad in).
// Modports: master = control unit + SRAM side environment, slave = the sequencer.
interface lc3_sram_ctrl_if
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              Req_rd;
    logic              Req_wr;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Wdata;
    logic              Ready;
    logic              Done;
    logic [DATA_W-1:0] Rdata;
    logic              Req_err;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic [DATA_W-1:0] SRAM_DQ_out;
    logic              SRAM_DQ_oe;
    logic [DATA_W-1:0] SRAM_DQ_in;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;

    modport master (
        output Req_rd, Req_wr, Addr, Wdata, SRAM_DQ_in,
        input  Ready, Done, Rdata, Req_err,
        input  SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
        input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );

    modport slave (
        input  Req_rd, Req_wr, Addr, Wdata, SRAM_DQ_in,
        output Ready, Done, Rdata, Req_err,
        output SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
        output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N
    );

endinterface

// File: rtl/lc3_sram_ctrl.sv
// rtl/lc3_sram_ctrl.sv - req/ready sequencer between the LC-3 control unit and an async SRAM
// Purpose: accepts one read or write per handshake, drives CE/OE/WE with parameterised
//   wait states, returns registered read data with a one-cycle Done pulse.
// Ports: Clk (rising-edge clock), Reset_n (async active-low reset),
//   bus (lc3_sram_ctrl_if.slave: request/status signals and SRAM pads).
module lc3_sram_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF,
    parameter int TURN    = TURN_DEF
) (
    input  logic           Clk,
    input  logic           Reset_n,
    lc3_sram_ctrl_if.slave bus
);

    localparam int CNT_MAX = max3(RD_WAIT, WR_WAIT, TURN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_WAIT);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              accept;
    logic              rd_sample;
    logic              last_wait;

    assign last_wait = (cnt_q == CNT_ONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        rd_sample = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Req_rd || bus.Req_wr) begin
                    accept = 1'b1;
                    // A simultaneous read+write request is resolved as a write.
                    if (bus.Req_wr) begin
                        state_d = ST_WR_SETUP;
                    end else begin
                        state_d = ST_RD;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            ST_RD: begin
                if (last_wait) begin
                    rd_sample = 1'b1;
                    done_d    = 1'b1;
                    if (TURN == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR;
                cnt_d   = WR_LOAD;
            end
            ST_WR: begin
                if (last_wait) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_WR_HOLD: begin
                done_d = 1'b1;
                if (TURN == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TURN;
                    cnt_d   = TURN_LOAD;
                end
            end
            ST_TURN: begin
                if (last_wait) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state and registered, so the pads change on the same
    // edge as the state and never see a combinational path from the request inputs.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            ST_WR: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
        err_d = accept && bus.Req_rd && bus.Req_wr;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
            if (accept) begin
                addr_q  <= bus.Addr;
                wdata_q <= bus.Wdata;
            end
            if (rd_sample) begin
                rdata_q <= bus.SRAM_DQ_in;
            end
        end
    end

    assign bus.Ready       = (state_q == ST_IDLE);
    assign bus.Done        = done_q;
    assign bus.Req_err     = err_q;
    assign bus.Rdata       = rdata_q;
    assign bus.SRAM_ADDR   = addr_q;
    assign bus.SRAM_DQ_out = wdata_q;
    assign bus.SRAM_DQ_oe  = dq_oe_q;
    assign bus.SRAM_CE_N   = ce_n_q;
    assign bus.SRAM_OE_N   = oe_n_q;
    assign bus.SRAM_WE_N   = we_n_q;
    // Always 16-bit accesses: byte lanes follow chip enable.
    assign bus.SRAM_UB_N   = ce_n_q;
    assign bus.SRAM_LB_N   = ce_n_q;

endmodule

// File: tb/tb_lc3_sram_ctrl.sv
// tb/tb_lc3_sram_ctrl.sv - directed self-checking bench for lc3_sram_ctrl
module tb_lc3_sram_ctrl;
    import lc3_mem_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;

    logic Clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    lc3_sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    lc3_sram_ctrl #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_WAIT(2),
        .WR_WAIT(2),
        .TURN   (1)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    // SRAM model: 256 words on the low address byte; 0x03000 is a fixed ROM word 0x1234.
    logic [15:0] mem [0:255];

    always @(posedge Clk) begin
        if (!bus.SRAM_CE_N && !bus.SRAM_WE_N) mem[bus.SRAM_ADDR[7:0]] <= bus.SRAM_DQ_out;
    end

    assign bus.SRAM_DQ_in = (!bus.SRAM_CE_N && !bus.SRAM_OE_N)
                          ? ((bus.SRAM_ADDR == 20'h03000) ? 16'h1234 : mem[bus.SRAM_ADDR[7:0]])
                          : 16'hDEAD;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        chk_b("oe_we_never_both_low", bus.SRAM_OE_N | bus.SRAM_WE_N, 1'b1);
        chk_b("dq_oe_off_while_oe_low", bus.SRAM_DQ_oe & ~bus.SRAM_OE_N, 1'b0);
    endtask

    // Called in the accept cycle; drops the request after the accept edge and measures
    // the access until Done (lat = 0 if Done never appears within the bound).
    task automatic run_access(output int lat, output int oe_lo, output int we_lo,
                              output int dq_hi, output int err_hi);
        lat = 0; oe_lo = 0; we_lo = 0; dq_hi = 0; err_hi = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                bus.Req_rd = 1'b0;
                bus.Req_wr = 1'b0;
            end
            if (!bus.SRAM_OE_N) oe_lo++;
            if (!bus.SRAM_WE_N) we_lo++;
            if (bus.SRAM_DQ_oe) dq_hi++;
            if (bus.Req_err)    err_hi++;
            if (bus.Done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10; i++) begin
            if (bus.Ready) break;
            tick();
        end
        chk_b("ready_returns", bus.Ready, 1'b1);
    endtask

    initial begin
        int lat, oe_lo, we_lo, dq_hi, err_hi, ndone;
        logic [15:0] oe_tr, done_tr, rdy_tr;

        Reset_n    = 1'b0;
        bus.Req_rd = 1'b0;
        bus.Req_wr = 1'b0;
        bus.Addr   = '0;
        bus.Wdata  = '0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        chk_b("rst_ready", bus.Ready, 1'b1);
        chk_b("rst_done", bus.Done, 1'b0);
        chk_b("rst_req_err", bus.Req_err, 1'b0);
        chk_w("rst_rdata", 32'(bus.Rdata), 32'h0);
        chk_w("rst_sram_addr", 32'(bus.SRAM_ADDR), 32'h0);
        chk_w("rst_dq_out", 32'(bus.SRAM_DQ_out), 32'h0);
        chk_b("rst_dq_oe", bus.SRAM_DQ_oe, 1'b0);
        chk_w("rst_strobes", 32'({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N,
                                  bus.SRAM_UB_N, bus.SRAM_LB_N}), 32'h1F);
        Reset_n = 1'b1;
        tick();

        // Read 0x3000 -> 0x1234, Done 3 cycles after accept, OE_N low 2 cycles
        bus.Addr   = 20'h03000;
        bus.Req_rd = 1'b1;
        chk_b("rd_ready_at_accept", bus.Ready, 1'b1);
        run_access(lat, oe_lo, we_lo, dq_hi, err_hi);
        chk_w("rd_latency", lat, 3);
        chk_w("rd_rdata", 32'(bus.Rdata), 32'h1234);
        chk_w("rd_oe_low_cycles", oe_lo, 2);
        chk_w("rd_we_low_cycles", we_lo, 0);
        chk_w("rd_dq_oe_cycles", dq_hi, 0);
        chk_w("rd_req_err", err_hi, 0);
        chk_w("rd_sram_addr", 32'(bus.SRAM_ADDR), 32'h03000);
        chk_b("rd_ready_low_in_turn", bus.Ready, 1'b0);
        wait_ready();

        // Write 0xBEEF to 0x0040, Done at accept+5, WE_N low 2, DQ_oe high 4
        bus.Addr   = 20'h00040;
        bus.Wdata  = 16'hBEEF;
        bus.Req_wr = 1'b1;
        run_access(lat, oe_lo, we_lo, dq_hi, err_hi);
        chk_w("wr_latency", lat, 5);
        chk_w("wr_we_low_cycles", we_lo, 2);
        chk_w("wr_dq_oe_cycles", dq_hi, 4);
        chk_w("wr_oe_low_cycles", oe_lo, 0);
        chk_w("wr_req_err", err_hi, 0);
        chk_w("wr_mem_0040", 32'(mem[8'h40]), 32'hBEEF);
        chk_w("wr_rdata_kept", 32'(bus.Rdata), 32'h1234);
        wait_ready();

        // Conflict: both requests -> write performed, one Req_err pulse, Rdata untouched
        bus.Addr   = 20'h00041;
        bus.Wdata  = 16'hCAFE;
        bus.Req_rd = 1'b1;
        bus.Req_wr = 1'b1;
        run_access(lat, oe_lo, we_lo, dq_hi, err_hi);
        chk_w("cf_latency", lat, 5);
        chk_w("cf_we_low_cycles", we_lo, 2);
        chk_w("cf_oe_low_cycles", oe_lo, 0);
        chk_w("cf_req_err_pulses", err_hi, 1);
        chk_w("cf_mem_0041", 32'(mem[8'h41]), 32'hCAFE);
        chk_w("cf_rdata_kept", 32'(bus.Rdata), 32'h1234);
        wait_ready();

        // Back-to-back reads of 0x0040 with Req_rd held. Per access: accept(IDLE), RD, RD,
        // TURN(Done); strobes separated by the TURN cycle plus the IDLE accept cycle.
        bus.Addr   = 20'h00040;
        bus.Req_rd = 1'b1;
        ndone      = 0;
        oe_tr      = '0;
        done_tr    = '0;
        rdy_tr     = '0;
        for (int t = 0; t < 16; t++) begin
            if (t > 0) tick();
            oe_tr[t]   = ~bus.SRAM_OE_N;
            done_tr[t] = bus.Done;
            rdy_tr[t]  = bus.Ready;
            if (bus.Done) ndone++;
            if (ndone == 3) bus.Req_rd = 1'b0;
        end
        chk_w("b2b_oe_trace", 32'(oe_tr), 32'h0666);
        chk_w("b2b_done_trace", 32'(done_tr), 32'h0888);
        chk_w("b2b_ready_trace", 32'(rdy_tr), 32'hF111);
        chk_w("b2b_done_count", ndone, 3);
        chk_w("b2b_rdata", 32'(bus.Rdata), 32'hBEEF);

        // Reset in the middle of WR: strobes release without a clock edge, no Done afterwards
        bus.Addr   = 20'h00042;
        bus.Wdata  = 16'h5555;
        bus.Req_wr = 1'b1;
        tick();
        bus.Req_wr = 1'b0;
        tick();
        chk_b("mid_wr_we_low", bus.SRAM_WE_N, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_b("arst_we_n", bus.SRAM_WE_N, 1'b1);
        chk_b("arst_ce_n", bus.SRAM_CE_N, 1'b1);
        chk_b("arst_dq_oe", bus.SRAM_DQ_oe, 1'b0);
        chk_b("arst_oe_n", bus.SRAM_OE_N, 1'b1);
        chk_b("arst_done", bus.Done, 1'b0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        chk_b("arst_ready_on_release", bus.Ready, 1'b1);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.Done) ndone++;
        end
        chk_w("arst_no_done", ndone, 0);
        chk_b("arst_ready_idle", bus.Ready, 1'b1);
        chk_w("arst_rdata_cleared", 32'(bus.Rdata), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
